// File: rtl/deserializer_fsm.sv
// -----------------------------------------------------------------------------
// deserializer_fsm
//
// Bit-serial to parallel converter. Bits arrive LSB first under a valid/ready
// handshake and are packed into LENGTH-bit words. Each finished word is shown
// on a parallel valid/ready port until the consumer takes it. While a word is
// waiting, the input is ready only when the consumer is ready, so the first bit
// of the next word can enter in the same cycle the previous word leaves.
//
// Optional feature: define DESER_TIMEOUT_EN to abandon a partial word after
// TIMEOUT_CYCLES enabled cycles with no accepted bit. o_timeout then pulses for
// one cycle. With the macro undefined, o_timeout is tied low and a partial word
// waits indefinitely.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset (overrides i_en)
//   i_en          clock enable; low freezes all state and outputs
//   i_din         serial data bit, LSB first
//   i_din_valid   i_din holds a valid bit
//   o_ready       block can accept a bit this cycle (combinational)
//   ov_dout       assembled word, bit 0 is the first bit received
//   o_dout_valid  ov_dout holds a complete word (registered)
//   i_ready       downstream accepts ov_dout
//   o_timeout     one-cycle pulse when a partial word is discarded
// -----------------------------------------------------------------------------
module deserializer_fsm #(
   parameter int LENGTH         = 24,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_din,
   input  logic              i_din_valid,
   output logic              o_ready,
   output logic [LENGTH-1:0] ov_dout,
   output logic              o_dout_valid,
   input  logic              i_ready,
   output logic              o_timeout
);

   localparam int CW = $clog2(LENGTH + 1);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_SHIFT_IN = 2'd1;
   localparam logic [1:0] ST_HOLD     = 2'd2;

   // Count value held while the last bit of a word is being offered.
   localparam logic [CW-1:0] LAST_COUNT = CW'(LENGTH - 1);

   logic [1:0]        state_reg, state_next;
   logic [CW-1:0]     count_reg, count_next;
   logic [LENGTH-1:0] shift_reg, shift_next;
   logic [LENGTH-1:0] dout_reg, dout_next;
   logic              dout_valid_reg, dout_valid_next;

   logic              ready_int;
   logic              bit_accept;
   logic              handoff;
   logic              word_done;
   logic [LENGTH-1:0] shifted_word;

   // New bit enters at the top; after LENGTH shifts the first bit sits at bit 0.
   generate
      if (LENGTH == 1) begin : g_one_bit
         assign shifted_word = i_din;
      end else begin : g_multi_bit
         assign shifted_word = {i_din, shift_reg[LENGTH-1:1]};
      end
   endgenerate

   always_comb begin
      ready_int = 1'b0;
      case (state_reg)
         ST_IDLE, ST_SHIFT_IN: ready_int = i_en;
         ST_HOLD:              ready_int = i_en & i_ready;
         default:              ready_int = 1'b0;
      endcase
   end

   assign bit_accept = i_en & i_din_valid & ready_int;
   assign handoff    = i_en & dout_valid_reg & i_ready;
   // count is 0 in IDLE and HOLD, so with LENGTH==1 every accepted bit completes a word.
   assign word_done  = bit_accept & (count_reg == LAST_COUNT);

`ifdef DESER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] idle_cnt_reg, idle_cnt_next;
   logic          timeout_reg, timeout_next;
`endif

   always_comb begin
      state_next      = state_reg;
      count_next      = count_reg;
      shift_next      = shift_reg;
      dout_next       = dout_reg;
      dout_valid_next = dout_valid_reg;
`ifdef DESER_TIMEOUT_EN
      idle_cnt_next   = '0;
      timeout_next    = 1'b0;
`endif

      if (bit_accept) begin
         shift_next = shifted_word;
         count_next = word_done ? '0 : count_reg + CW'(1);
      end

      if (word_done) begin
         dout_next       = shifted_word;
         dout_valid_next = 1'b1;
      end else if (handoff) begin
         dout_valid_next = 1'b0;
      end

      case (state_reg)
         ST_IDLE: begin
            if (bit_accept)
               state_next = word_done ? ST_HOLD : ST_SHIFT_IN;
         end
         ST_SHIFT_IN: begin
            if (word_done) begin
               state_next = ST_HOLD;
            end
`ifdef DESER_TIMEOUT_EN
            else if (!bit_accept) begin
               if (idle_cnt_reg == IDLE_LIMIT) begin
                  state_next   = ST_IDLE;
                  shift_next   = '0;
                  count_next   = '0;
                  timeout_next = 1'b1;
               end else begin
                  idle_cnt_next = idle_cnt_reg + TW'(1);
               end
            end
`endif
         end
         ST_HOLD: begin
            if (handoff) begin
               if (bit_accept)
                  state_next = word_done ? ST_HOLD : ST_SHIFT_IN;
               else
                  state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg      <= ST_IDLE;
         count_reg      <= '0;
         shift_reg      <= '0;
         dout_reg       <= '0;
         dout_valid_reg <= 1'b0;
      end else if (i_en) begin
         state_reg      <= state_next;
         count_reg      <= count_next;
         shift_reg      <= shift_next;
         dout_reg       <= dout_next;
         dout_valid_reg <= dout_valid_next;
      end
   end

`ifdef DESER_TIMEOUT_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         idle_cnt_reg <= '0;
         timeout_reg  <= 1'b0;
      end else if (i_en) begin
         idle_cnt_reg <= idle_cnt_next;
         timeout_reg  <= timeout_next;
      end
   end

   assign o_timeout = timeout_reg;
`else
   assign o_timeout = 1'b0;
`endif

   assign o_ready      = ready_int;
   assign ov_dout      = dout_reg;
   assign o_dout_valid = dout_valid_reg;

endmodule
